// File: rtl/mpeg_decode_scheduler.sv
// -----------------------------------------------------------------------------
// mpeg_decode_scheduler
//
// Buffers decoding timestamps of incoming access units and releases each one to
// the decoder when its decode time is reached. The time base is a 45 kHz counter
// (dclk), doubled to 90 kHz. A unit whose lateness exceeds LATE_LIMIT ticks is
// dropped instead of being decoded.
//
// Ports:
//   clk, reset_n          clock (rising edge) and async active-low reset
//   dclk[31:0]            free-running 45 kHz time counter
//   ts_in[32:0]/ts_valid  timestamp of the next unit; one-cycle push strobe
//   start_time[32:0]      stream start time, qualified by start_valid (level)
//   program_end           one-cycle pulse; flush all pending units
//   pause                 level; blocks new decode releases (not skips)
//   decode_req/decode_ts  request to decode the head unit, and its timestamp
//   decode_ack            decoder accepts the pending request
//   skip_pulse            one-cycle pulse; the head unit was dropped as late
//   overflow              sticky; a push was lost on a full FIFO
//   level                 FIFO occupancy
//   end_done              one-cycle pulse; program_end flush has completed
// -----------------------------------------------------------------------------
module mpeg_decode_scheduler #(
  parameter int DEPTH      = 4,
  parameter int LATE_LIMIT = 9000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            dclk,
  input  logic [32:0]            ts_in,
  input  logic                   ts_valid,
  input  logic [32:0]            start_time,
  input  logic                   start_valid,
  input  logic                   program_end,
  input  logic                   pause,
  output logic                   decode_req,
  output logic [32:0]            decode_ts,
  input  logic                   decode_ack,
  output logic                   skip_pulse,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level,
  output logic                   end_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0]        FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0]        ZERO_L = LW'(0);
  localparam logic [LW-1:0]        ONE_L  = LW'(1);
  localparam logic [PW-1:0]        ZERO_P = PW'(0);
  localparam logic [PW-1:0]        ONE_P  = PW'(1);
  localparam logic signed [32:0]   LATE_S = 33'(LATE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DUE = 2'd1,
    ST_REQ      = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [32:0]        mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [LW-1:0]      count_r;
  logic [LW-1:0]      count_next_s;

  logic               req_r;
  logic               req_next_s;
  logic [32:0]        ts_r;
  logic [32:0]        ts_next_s;
  logic               skip_r;
  logic               skip_next_s;
  logic               done_r;
  logic               done_next_s;
  logic               ovf_r;
  // Remembers a program_end seen while a request is outstanding, so the flush
  // runs only after the decoder has taken that unit.
  logic               pend_r;
  logic               pend_next_s;

  logic               pop_s;
  logic               push_s;
  logic               ovf_set_s;
  logic               flush_s;
  logic [32:0]        head_ts_s;
  logic [32:0]        now_s;
  logic signed [32:0] slack_s;

  // Head of FIFO and the wrap-around lateness of that unit in 90 kHz ticks.
  always_comb begin
    head_ts_s = mem_r[rd_ptr_r];
    now_s     = {dclk, 1'b0};
    slack_s   = now_s - start_time - head_ts_s;
  end

  // Release FSM: next state and next values of the registered outputs.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    req_next_s   = req_r;
    ts_next_s    = ts_r;
    skip_next_s  = 1'b0;
    done_next_s  = 1'b0;
    pend_next_s  = pend_r;
    case (state_r)
      ST_IDLE: begin
        if (program_end) begin
          state_next_s = ST_FLUSH;
        end else if (start_valid && (count_r != ZERO_L)) begin
          state_next_s = ST_WAIT_DUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_DUE: begin
        if (program_end) begin
          state_next_s = ST_FLUSH;
        end else if (!start_valid) begin
          state_next_s = ST_IDLE;
        end else if (slack_s > LATE_S) begin
          // Too late: dropped even when paused.
          pop_s        = 1'b1;
          skip_next_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else if (!slack_s[32] && !pause) begin
          req_next_s   = 1'b1;
          ts_next_s    = head_ts_s;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_WAIT_DUE;
        end
      end
      ST_REQ: begin
        if (decode_ack) begin
          pop_s        = 1'b1;
          req_next_s   = 1'b0;
          pend_next_s  = 1'b0;
          state_next_s = (pend_r || program_end) ? ST_FLUSH : ST_IDLE;
        end else if (program_end) begin
          pend_next_s  = 1'b1;
        end else begin
          pend_next_s  = pend_r;
        end
      end
      ST_FLUSH: begin
        done_next_s  = 1'b1;
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        req_next_s   = 1'b0;
        pend_next_s  = 1'b0;
      end
    endcase
  end

  // FIFO push acceptance, overflow detection and occupancy update.
  always_comb begin
    flush_s   = (state_r == ST_FLUSH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s    = ts_valid && !flush_s && ((count_r != FULL_L) || pop_s);
    ovf_set_s = ts_valid && !flush_s && (count_r == FULL_L) && !pop_s;
    if (flush_s) begin
      count_next_s = ZERO_L;
    end else if (push_s && !pop_s) begin
      count_next_s = count_r + ONE_L;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - ONE_L;
    end else begin
      count_next_s = count_r;
    end
  end

  // State, FIFO storage/pointers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= ZERO_P;
      rd_ptr_r <= ZERO_P;
      count_r  <= ZERO_L;
      req_r    <= 1'b0;
      ts_r     <= 33'd0;
      skip_r   <= 1'b0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      pend_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 33'd0;
      end
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      req_r   <= req_next_s;
      ts_r    <= ts_next_s;
      skip_r  <= skip_next_s;
      done_r  <= done_next_s;
      pend_r  <= pend_next_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
      if (push_s) begin
        mem_r[wr_ptr_r] <= ts_in;
      end
      if (flush_s) begin
        wr_ptr_r <= ZERO_P;
        rd_ptr_r <= ZERO_P;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + ONE_P;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + ONE_P;
        end
      end
    end
  end

  assign decode_req = req_r;
  assign decode_ts  = ts_r;
  assign skip_pulse = skip_r;
  assign overflow   = ovf_r;
  assign level      = count_r;
  assign end_done   = done_r;

endmodule

// File: tb/tb_mpeg_decode_scheduler.sv
module tb_mpeg_decode_scheduler;

  localparam int DEPTH = 4;
  localparam logic signed [32:0] LATE_S = 33'sd9000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] dclk = 32'd0;
  logic [32:0] ts_in = 33'd0;
  logic        ts_valid = 1'b0;
  logic [32:0] start_time = 33'd0;
  logic        start_valid = 1'b0;
  logic        program_end = 1'b0;
  logic        pause = 1'b0;
  logic        decode_req;
  logic [32:0] decode_ts;
  logic        decode_ack = 1'b0;
  logic        skip_pulse;
  logic        overflow;
  logic [2:0]  level;
  logic        end_done;

  int checks = 0;
  int errors = 0;

  mpeg_decode_scheduler #(.DEPTH(DEPTH), .LATE_LIMIT(9000)) dut (
    .clk(clk), .reset_n(reset_n), .dclk(dclk), .ts_in(ts_in), .ts_valid(ts_valid),
    .start_time(start_time), .start_valid(start_valid), .program_end(program_end),
    .pause(pause), .decode_req(decode_req), .decode_ts(decode_ts),
    .decode_ack(decode_ack), .skip_pulse(skip_pulse), .overflow(overflow),
    .level(level), .end_done(end_done)
  );

  always #5 clk = ~clk;

  // Lateness of a unit: 90 kHz now minus start time minus its timestamp.
  function automatic logic signed [32:0] slack_of(input logic [31:0] d,
                                                 input logic [32:0] st,
                                                 input logic [32:0] ts);
    logic [32:0] now;
    now = {d, 1'b0};
    return now - st - ts;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [32:0] v);
    ts_in = v;
    ts_valid = 1'b1;
    step();
    ts_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ts_valid = 1'b0; program_end = 1'b0; decode_ack = 1'b0; pause = 1'b0;
    start_valid = 1'b0; start_time = 33'd0; dclk = 32'd0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++; if (decode_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", decode_req); end
    checks++; if (decode_ts !== 33'd0) begin errors++; $display("FAIL reset_ts got %0d exp 0", decode_ts); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if ({skip_pulse, overflow, end_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {skip_pulse, overflow, end_done}); end
    do_reset();
    checks++; if (decode_req !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL post_reset got req %0b lvl %0d exp 0 0", decode_req, level); end
  endtask

  task automatic test_release();
    do_reset();
    start_valid = 1'b1; dclk = 32'd499;
    push(33'd1000);
    step(); step();
    checks++; if (decode_req !== 1'b0) begin errors++; $display("FAIL early_req got %0b exp 0", decode_req); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL release_level got %0d exp 1", level); end
    dclk = 32'd500;
    step();
    checks++; if (decode_req !== 1'b1) begin errors++; $display("FAIL release_latency got %0b exp 1", decode_req); end
    checks++; if (decode_ts !== 33'd1000) begin errors++; $display("FAIL release_ts got %0d exp 1000", decode_ts); end
    decode_ack = 1'b1; step(); decode_ack = 1'b0;
    checks++; if (decode_req !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL release_ack got req %0b lvl %0d exp 0 0", decode_req, level); end
  endtask

  task automatic test_skip();
    int skips = 0, reqs = 0;
    do_reset();
    start_valid = 1'b1; dclk = 32'd6000;
    push(33'd1000);
    for (int i = 0; i < 4; i++) begin
      step();
      if (skip_pulse === 1'b1) skips++;
      if (decode_req === 1'b1) reqs++;
    end
    checks++; if (skips != 1) begin errors++; $display("FAIL skip_count got %0d exp 1", skips); end
    checks++; if (reqs != 0) begin errors++; $display("FAIL skip_req got %0d exp 0", reqs); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL skip_level got %0d exp 0", level); end
  endtask

  task automatic test_late_boundary();
    int skips = 0, reqs = 0;
    do_reset();
    start_valid = 1'b1; dclk = 32'd5000;
    push(33'd1000);  // slack exactly 9000: released
    for (int i = 0; i < 3; i++) begin
      step();
      if (skip_pulse === 1'b1) skips++;
      if (decode_req === 1'b1) reqs++;
    end
    checks++; if (reqs == 0 || skips != 0) begin errors++; $display("FAIL late_edge_release got req %0d skip %0d exp >0 0", reqs, skips); end
    checks++; if (decode_ts !== 33'd1000) begin errors++; $display("FAIL late_edge_ts got %0d exp 1000", decode_ts); end
    decode_ack = 1'b1; step(); decode_ack = 1'b0;
    skips = 0; reqs = 0;
    push(33'd999);   // slack 9001: skipped
    for (int i = 0; i < 3; i++) begin
      step();
      if (skip_pulse === 1'b1) skips++;
      if (decode_req === 1'b1) reqs++;
    end
    checks++; if (reqs != 0 || skips != 1) begin errors++; $display("FAIL late_edge_skip got req %0d skip %0d exp 0 1", reqs, skips); end
  endtask

  task automatic test_overflow();
    do_reset();
    dclk = 32'd10;
    for (int i = 0; i < 5; i++) push(33'(11 + i));
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    start_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4 && decode_req !== 1'b1; n++) step();
      checks++; if (decode_req !== 1'b1 || decode_ts !== 33'(11 + k)) begin errors++; $display("FAIL ovf_order got req %0b ts %0d exp 1 %0d", decode_req, decode_ts, 11 + k); end
      decode_ack = 1'b1; step(); decode_ack = 1'b0;
    end
    checks++; if (level !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drain got lvl %0d ovf %0b exp 0 1", level, overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dclk = 32'd10;
    for (int i = 0; i < 4; i++) push(33'(1 + i));
    start_valid = 1'b1;
    step(); step();
    checks++; if (decode_req !== 1'b1 || decode_ts !== 33'd1) begin errors++; $display("FAIL b2b_req got req %0b ts %0d exp 1 1", decode_req, decode_ts); end
    decode_ack = 1'b1; ts_in = 33'd5; ts_valid = 1'b1;
    step();
    decode_ack = 1'b0; ts_valid = 1'b0;
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL b2b_full got lvl %0d ovf %0b exp 4 0", level, overflow); end
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4 && decode_req !== 1'b1; n++) step();
      checks++; if (decode_req !== 1'b1 || decode_ts !== 33'(2 + k)) begin errors++; $display("FAIL b2b_order got req %0b ts %0d exp 1 %0d", decode_req, decode_ts, 2 + k); end
      decode_ack = 1'b1; step(); decode_ack = 1'b0;
    end
  endtask

  task automatic test_pause();
    int reqs = 0;
    do_reset();
    start_valid = 1'b1; dclk = 32'd505; pause = 1'b1;
    push(33'd1000);
    for (int i = 0; i < 4; i++) begin
      step();
      if (decode_req === 1'b1) reqs++;
    end
    checks++; if (reqs != 0) begin errors++; $display("FAIL pause_hold got %0d exp 0", reqs); end
    pause = 1'b0;
    step();
    checks++; if (decode_req !== 1'b1 || decode_ts !== 33'd1000) begin errors++; $display("FAIL pause_release got req %0b ts %0d exp 1 1000", decode_req, decode_ts); end
    decode_ack = 1'b1; step(); decode_ack = 1'b0;
  endtask

  task automatic test_program_end();
    do_reset();
    dclk = 32'd505;
    push(33'd1000); push(33'd1001); push(33'd1002);
    start_valid = 1'b1;
    step(); step();
    checks++; if (decode_req !== 1'b1 || level !== 3'd3) begin errors++; $display("FAIL pe_setup got req %0b lvl %0d exp 1 3", decode_req, level); end
    program_end = 1'b1; step(); program_end = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (decode_req !== 1'b1 || decode_ts !== 33'd1000 || level !== 3'd3 || end_done !== 1'b0) begin errors++; $display("FAIL pe_hold got req %0b ts %0d lvl %0d done %0b exp 1 1000 3 0", decode_req, decode_ts, level, end_done); end
      step();
    end
    decode_ack = 1'b1; step(); decode_ack = 1'b0;
    checks++; if (decode_req !== 1'b0 || level !== 3'd2) begin errors++; $display("FAIL pe_ack got req %0b lvl %0d exp 0 2", decode_req, level); end
    ts_in = 33'd5; ts_valid = 1'b1; step(); ts_valid = 1'b0;
    checks++; if (level !== 3'd0 || end_done !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL pe_flush got lvl %0d done %0b ovf %0b exp 0 1 0", level, end_done, overflow); end
    step();
    checks++; if (end_done !== 1'b0 || level !== 3'd0 || decode_req !== 1'b0) begin errors++; $display("FAIL pe_once got done %0b lvl %0d req %0b exp 0 0 0", end_done, level, decode_req); end
  endtask

  task automatic test_start_drop();
    do_reset();
    start_valid = 1'b1;
    push(33'd1000);
    step(); step();
    start_valid = 1'b0; step();
    dclk = 32'd500;
    step(); step(); step();
    checks++; if (decode_req !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL sv_drop got req %0b lvl %0d exp 0 1", decode_req, level); end
    start_valid = 1'b1;
    step(); step();
    checks++; if (decode_req !== 1'b1 || decode_ts !== 33'd1000) begin errors++; $display("FAIL sv_resume got req %0b ts %0d exp 1 1000", decode_req, decode_ts); end
    decode_ack = 1'b1; step(); decode_ack = 1'b0;
  endtask

  task automatic test_reset_midhandshake();
    do_reset();
    start_valid = 1'b1; dclk = 32'd500;
    push(33'd1000);
    step(); step();
    checks++; if (decode_req !== 1'b1) begin errors++; $display("FAIL mid_setup got %0b exp 1", decode_req); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (decode_req !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_async got req %0b lvl %0d exp 0 0", decode_req, level); end
    decode_ack = 1'b1;
    #1 reset_n = 1'b1;
    step(); decode_ack = 1'b0; step();
    checks++; if (decode_req !== 1'b0 || level !== 3'd0 || skip_pulse !== 1'b0) begin errors++; $display("FAIL mid_ack_ignored got req %0b lvl %0d exp 0 0", decode_req, level); end
  endtask

  task automatic test_random();
    logic [32:0] q[$];
    logic ovf_m = 1'b0;
    logic [31:0] a_dclk;
    logic [32:0] a_ts, prev_ts;
    logic a_tv, a_ack, a_pause, a_sv, req_before, pop;
    logic signed [32:0] sl;
    int sz;
    do_reset();
    start_time = 33'($urandom_range(0, 200000));
    dclk = $urandom_range(0, 100000);
    start_valid = 1'b1;
    prev_ts = decode_ts;
    for (int c = 0; c < 600; c++) begin
      sl = 33'sd0 + ($signed($urandom_range(0, 16000)) - 4000);
      a_tv = ($urandom_range(0, 3) == 0);
      a_ts = {dclk, 1'b0} - start_time - sl;
      a_pause = ($urandom_range(0, 7) == 0);
      a_sv = ($urandom_range(0, 39) != 0);
      a_ack = (decode_req === 1'b1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      a_dclk = dclk;
      req_before = decode_req;
      sz = q.size();
      ts_valid = a_tv; ts_in = a_ts; pause = a_pause; start_valid = a_sv; decode_ack = a_ack;
      step();
      dclk = dclk + $urandom_range(0, 400);
      pop = (a_ack && req_before) || (skip_pulse === 1'b1);
      if (skip_pulse === 1'b1) begin
        checks++;
        if (sz == 0 || slack_of(a_dclk, start_time, q[0]) <= LATE_S) begin
          errors++; $display("FAIL rnd_skip cycle %0d got skip with slack %0d exp slack > 9000", c, (sz == 0) ? 0 : slack_of(a_dclk, start_time, q[0]));
        end
      end
      if (decode_req === 1'b1 && req_before !== 1'b1) begin
        checks++;
        if (sz == 0 || decode_ts !== q[0] || a_pause || !a_sv ||
            slack_of(a_dclk, start_time, q[0]) < 0 || slack_of(a_dclk, start_time, q[0]) > LATE_S) begin
          errors++; $display("FAIL rnd_release cycle %0d got ts %0d exp head %0d with 0<=slack<=9000 unpaused", c, decode_ts, (sz == 0) ? 33'd0 : q[0]);
        end
      end
      if (req_before === 1'b1) begin
        checks++;
        if (a_ack ? (decode_req !== 1'b0) : (decode_req !== 1'b1 || decode_ts !== prev_ts)) begin
          errors++; $display("FAIL rnd_handshake cycle %0d got req %0b ts %0d exp req %0b ts %0d", c, decode_req, decode_ts, !a_ack, prev_ts);
        end
      end
      if (pop && sz > 0) void'(q.pop_front());
      if (a_tv) begin
        if (sz < DEPTH || pop) q.push_back(a_ts);
        else ovf_m = 1'b1;
      end
      checks++;
      if (level !== 3'(q.size()) || overflow !== ovf_m) begin
        errors++; $display("FAIL rnd_level cycle %0d got lvl %0d ovf %0b exp %0d %0b", c, level, overflow, q.size(), ovf_m);
      end
      prev_ts = decode_ts;
    end
    ts_valid = 1'b0; decode_ack = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_release();
    test_skip();
    test_late_boundary();
    test_overflow();
    test_back_to_back();
    test_pause();
    test_program_end();
    test_start_drop();
    test_reset_midhandshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpeg_decode_scheduler.md
MPEG_DECODE_SCHEDULER -- requirements
Module: mpeg_decode_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, timestamp FIFO entries (power of two, 2..16).
REQ-002 Parameter LATE_LIMIT, default 9000, lateness in 90 kHz ticks beyond which a unit is skipped.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 dclk  input  32  free-running 45 kHz time counter.
REQ-006 ts_in  input  33  signed decoding timestamp of the next access unit, 90 kHz units.
REQ-007 ts_valid  input  1  one-cycle pulse; ts_in is valid.
REQ-008 start_time  input  33  signed stream start time, 90 kHz units.
REQ-009 start_valid  input  1  level; start_time is valid.
REQ-010 program_end  input  1  one-cycle pulse; end of program.
REQ-011 pause  input  1  level; inhibits new decode releases.
REQ-012 decode_req  output  1  request to decoder to decode the head unit.
REQ-013 decode_ts  output  33  timestamp of the unit under request.
REQ-014 decode_ack  input  1  decoder accepts the request.
REQ-015 skip_pulse  output  1  one-cycle pulse; head unit dropped as late.
REQ-016 overflow  output  1  sticky; a ts_valid was lost because the FIFO was full.
REQ-017 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 end_done  output  1  one-cycle pulse; program_end flush completed.

Function
REQ-019 ts_valid SHALL push ts_in into the FIFO tail when level<DEPTH; when full it SHALL drop ts_in and set overflow.
REQ-020 Push and pop in the same cycle with level==DEPTH SHALL succeed for both; level unchanged.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 now SHALL be {dclk,1'b0} truncated to 33 bits; slack SHALL be the signed 33-bit wrap-around value now - start_time - head_ts.
REQ-023 States: IDLE, WAIT_DUE, REQ, FLUSH.
REQ-024 IDLE -> WAIT_DUE when start_valid=1 and level>0.
REQ-025 WAIT_DUE with slack<0 SHALL remain in WAIT_DUE.
REQ-026 WAIT_DUE with slack>LATE_LIMIT SHALL pop the head, pulse skip_pulse, and go to IDLE; this SHALL happen regardless of pause.
REQ-027 WAIT_DUE with 0<=slack<=LATE_LIMIT and pause=0 SHALL go to REQ; decode_req=1 and decode_ts=head_ts SHALL be set on the same edge.
REQ-028 In REQ, decode_req and decode_ts SHALL remain stable until decode_ack=1. On that edge the head SHALL be popped, decode_req cleared, and the state SHALL go to IDLE.
REQ-029 decode_ack outside REQ SHALL be ignored.
REQ-030 Release latency: decode_req SHALL rise 1 cycle after slack first becomes >=0, given that the state is already WAIT_DUE.
REQ-031 program_end in any state SHALL go to FLUSH. If in REQ, decode_req SHALL be held until decode_ack, and that ack SHALL pop the head.
REQ-032 FLUSH SHALL empty the FIFO, pulse end_done once, and return to IDLE. Pushes during FLUSH SHALL be discarded and SHALL NOT set overflow.
REQ-033 start_valid falling SHALL return WAIT_DUE to IDLE; the FIFO SHALL be kept.
REQ-034 At most one pop per cycle.

Reset
REQ-035 While reset_n=0: FIFO empty, pointers 0, state IDLE, and all outputs 0.
REQ-036 Reset SHALL take effect immediately, including mid-handshake. decode_req SHALL drop without waiting for ack, and a later ack SHALL be ignored.

Verification
REQ-037 start_time=0, push ts=1000, dclk steps 499->500 -> decode_req rises the cycle after dclk=500 with decode_ts=1000; ack -> level 0.
REQ-038 start_time=0, push ts=1000, dclk=6000 (slack 11000 > 9000) -> skip_pulse once, level 0, decode_req stays 0.
REQ-039 DEPTH=4: five ts_valid pulses with no pops -> level=4 and overflow=1; the first four values are released in order.
REQ-040 pause=1 with slack=10 -> no decode_req; pause=0 -> decode_req on the next cycle.
REQ-041 program_end during REQ with level=3 -> decode_req held until ack, then FLUSH; level=0 and end_done pulses once.
REQ-042 reset_n low while decode_req=1 -> decode_req=0 and level=0 immediately, with no clock edge needed.
